ripple_count_monitor: RTL and testbench
=======================================

Name: ripple_count_monitor

Overview:
- Downstream consumer of the 3-bit asynchronous JK ripple up-counter.
- Brings the ripple count into the clk domain through a two-flop synchronizer and a stability filter that rejects ripple transients.
- Tracks accepted values and flags legal steps, 7->0 wraps, threshold matches and illegal jumps.
- Gives system-clock logic clean, glitch-free counter events.

Parameters:
- STABLE_CYCLES, 2, consecutive clk cycles a synchronized value must hold before acceptance (legal range 1..15).
- WRAP_W, 8, width of the saturating wrap counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ripple_count  in  3  ripple-counter output, asynchronous to clk
- clr  in  1  synchronous clear of err and wrap_cnt; forces re-acquire when in ERROR
- match_val  in  3  threshold for match_pulse, quasi-static
- count_valid  out  1  a baseline value has been accepted
- count_sync  out  3  last accepted (filtered) count
- step_pulse  out  1  one-cycle pulse on a legal +1 step
- wrap_pulse  out  1  one-cycle pulse on a 7->0 step
- match_pulse  out  1  one-cycle pulse when the newly accepted value equals match_val
- wrap_cnt  out  WRAP_W  number of wraps, saturating at all-ones
- err  out  1  sticky; an illegal transition was seen

Behaviour:
- Reset values:
  - all outputs 0
  - synchronizer flops s1, s2 = 0
  - stability counter = 0
  - FSM = ACQUIRE
- Synchronizer: s1 <= ripple_count, s2 <= s1.
- Stability counter:
  - Clears when s2 differs from its previous-cycle value; otherwise increments, saturating.
  - A candidate equal to s2 is accepted when the counter reaches STABLE_CYCLES-1 and s2 != count_sync. In ACQUIRE, acceptance does not require s2 != count_sync.
- Latency: when ripple_count settles before a clk edge, count_sync updates on the (2+STABLE_CYCLES)th edge. With default 2, that is edge 4.
- Glitch rejection: any ripple intermediate value that holds in s2 for fewer than STABLE_CYCLES cycles is never accepted. Example: transient 2, 0 during 3->4.
- Step classification: diff = (candidate - count_sync) mod 8.
- FSM states:
  - ACQUIRE:
    - first acceptance loads count_sync, sets count_valid=1, goes to TRACK
    - no pulses
  - TRACK, on acceptance:
    - diff==1: step_pulse=1; if old value was 7, also wrap_pulse=1 and wrap_cnt increments (saturating)
    - match_pulse=1 if candidate==match_val and diff==1
    - diff is neither 0 nor 1: count_sync updated, err=1, no pulses, go to ERROR
  - ERROR:
    - count_sync keeps following accepted values
    - all pulses suppressed
    - err held at 1
    - clr: err=0, wrap_cnt=0, count_valid=0, go to ACQUIRE
- clr in TRACK:
  - wrap_cnt=0, err already 0, state unchanged
  - a same-cycle wrap still pulses, but wrap_cnt ends at 0 (clear has priority)
- All pulse outputs are registered, exactly one cycle wide, never back-to-back unless STABLE_CYCLES=1.
- match_val is sampled on the acceptance cycle only.
- rst asserted mid-operation: immediate return to reset values; the first post-reset acceptance is treated as a baseline, never as a step.

Decomposition:
- Package ripple_mon_pkg:
  - COUNT_W=3
  - FSM state enum {ACQUIRE, TRACK, ERROR}
  - function mod-8 difference
- Sub-module ripple_sync_filter:
  - contents: two-flop synchronizer plus stability counter
  - ports: clk, rst, async_in[2:0], accept, cand[2:0]
  - the top level holds the FSM, classification and counters.

Test Plan:
- Reset release with ripple_count=5, STABLE_CYCLES=2 -> count_sync=5 and count_valid=1 at edge 4; no pulses.
- Baseline 3, then ripple sequence 2, 0 (1 cycle each), then 4 held -> no acceptance of 2 or 0; step_pulse once; count_sync=4.
- Drive 0..7..0 with each value held 6 cycles -> 8 step_pulse, 1 wrap_pulse on 7->0, wrap_cnt=1, err=0.
- match_val=6 during a 0..7 sweep -> single match_pulse on acceptance of 6.
- Baseline 2, jump to 5 -> err=1, ERROR, no pulses; further steps produce no pulses; clr -> ACQUIRE, err=0, next value re-baselines.
- WRAP_W=2, 5 wraps -> wrap_cnt saturates at 3; clr coincident with a wrap acceptance -> wrap_pulse=1, wrap_cnt=0.

Source files
------------

// File: rtl/ripple_count_monitor_pkg.sv
// Shared types and helpers for the ripple-count monitor slice.
package ripple_mon_pkg;

    localparam int unsigned COUNT_W = 3;

    typedef enum logic [1:0] {
        ACQUIRE,
        TRACK,
        ERROR
    } mon_state_t;

    function automatic logic [COUNT_W-1:0] diff_mod8(input logic [COUNT_W-1:0] a,
                                                     input logic [COUNT_W-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/ripple_sync_filter.sv
// Two-flop synchronizer plus stability counter; flags a candidate once it has held long enough.
module ripple_sync_filter
    import ripple_mon_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] async_in,
    output logic               accept,
    output logic [COUNT_W-1:0] cand
);

    logic [COUNT_W-1:0] s1;
    logic [COUNT_W-1:0] s2;
    logic [3:0]         stab_cnt;
    logic [1:0]         primed;

    // primed keeps the reset value of s2 from counting as a stable sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= '0;
            s2       <= '0;
            stab_cnt <= '0;
            primed   <= '0;
        end else begin
            s1     <= async_in;
            s2     <= s1;
            primed <= {primed[0], 1'b1};
            if (!primed[1] || (s1 != s2)) begin
                stab_cnt <= '0;
            end else if (stab_cnt != '1) begin
                stab_cnt <= stab_cnt + 4'd1;
            end
        end
    end

    assign cand   = s2;
    assign accept = primed[1] && (stab_cnt == 4'(STABLE_CYCLES - 1));

endmodule

// File: rtl/ripple_count_monitor.sv
// Filters the asynchronous ripple count and emits clean step/wrap/match events in the clk domain.
module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 2,
    parameter int unsigned WRAP_W        = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] ripple_count,
    input  logic               clr,
    input  logic [COUNT_W-1:0] match_val,
    output logic               count_valid,
    output logic [COUNT_W-1:0] count_sync,
    output logic               step_pulse,
    output logic               wrap_pulse,
    output logic               match_pulse,
    output logic [WRAP_W-1:0]  wrap_cnt,
    output logic               err
);

    logic               accept;
    logic [COUNT_W-1:0] cand;
    logic               take;
    logic [COUNT_W-1:0] diff;
    mon_state_t         state;

    ripple_sync_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk     (clk),
        .rst     (rst),
        .async_in(ripple_count),
        .accept  (accept),
        .cand    (cand)
    );

    always_comb begin
        take = accept && ((state == ACQUIRE) || (cand != count_sync));
        diff = diff_mod8(cand, count_sync);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ACQUIRE;
            count_valid <= 1'b0;
            count_sync  <= '0;
            step_pulse  <= 1'b0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            wrap_cnt    <= '0;
            err         <= 1'b0;
        end else begin
            step_pulse  <= 1'b0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            case (state)
                ACQUIRE: begin
                    if (take) begin
                        count_sync  <= cand;
                        count_valid <= 1'b1;
                        state       <= TRACK;
                    end
                    if (clr) begin
                        err      <= 1'b0;
                        wrap_cnt <= '0;
                    end
                end
                TRACK: begin
                    if (take) begin
                        count_sync <= cand;
                        if (diff == 3'd1) begin
                            step_pulse  <= 1'b1;
                            match_pulse <= (cand == match_val);
                            if (count_sync == '1) begin
                                wrap_pulse <= 1'b1;
                                if (wrap_cnt != '1) wrap_cnt <= wrap_cnt + WRAP_W'(1);
                            end
                        end else begin
                            err   <= 1'b1;
                            state <= ERROR;
                        end
                    end
                    // clear wins over a same-cycle wrap increment
                    if (clr) wrap_cnt <= '0;
                end
                ERROR: begin
                    if (take) count_sync <= cand;
                    if (clr) begin
                        err         <= 1'b0;
                        wrap_cnt    <= '0;
                        count_valid <= 1'b0;
                        state       <= ACQUIRE;
                    end
                end
                default: state <= ACQUIRE;
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Randomized bench for ripple_count_monitor against a history-based behavioural model.
module tb_ripple_count_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ripple_count = '0;
    logic       clr = 1'b0;
    logic [2:0] match_val = '0;

    logic       a_valid, a_step, a_wrap, a_match, a_err;
    logic [2:0] a_sync;
    logic [7:0] a_wcnt;
    logic       b_valid, b_step, b_wrap, b_match, b_err;
    logic [2:0] b_sync;
    logic [1:0] b_wcnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ripple_count_monitor dut_a (
        .clk(clk), .rst(rst), .ripple_count(ripple_count), .clr(clr), .match_val(match_val),
        .count_valid(a_valid), .count_sync(a_sync), .step_pulse(a_step), .wrap_pulse(a_wrap),
        .match_pulse(a_match), .wrap_cnt(a_wcnt), .err(a_err)
    );

    ripple_count_monitor #(.STABLE_CYCLES(3), .WRAP_W(2)) dut_b (
        .clk(clk), .rst(rst), .ripple_count(ripple_count), .clr(clr), .match_val(match_val),
        .count_valid(b_valid), .count_sync(b_sync), .step_pulse(b_step), .wrap_pulse(b_wrap),
        .match_pulse(b_match), .wrap_cnt(b_wcnt), .err(b_err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int q_hist[$];          // real synchronized samples, oldest first
    int m_s1;
    bit m_s1v;
    int S_CFG[2] = '{2, 3};
    int WMAX[2]  = '{255, 3};
    int m_valid[2], m_sync[2], m_step[2], m_wrap[2], m_match[2], m_wcnt[2], m_err[2];
    int m_mode[2];          // 0 acquire, 1 track, 2 error

    // a value is accepted when the newest S samples agree and it is a fresh run
    function automatic bit stable_run(input int s);
        int n = q_hist.size();
        int v;
        if (n < s) return 1'b0;
        v = q_hist[n-1];
        for (int k = 1; k < s; k++) if (q_hist[n-1-k] != v) return 1'b0;
        if (n > s && q_hist[n-1-s] == v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input int i);
        bit acc = stable_run(S_CFG[i]);
        int cand = acc ? q_hist[q_hist.size()-1] : 0;
        int old_mode = m_mode[i];
        m_step[i] = 0; m_wrap[i] = 0; m_match[i] = 0;
        if (acc && (old_mode == 0 || cand != m_sync[i])) begin
            if (old_mode == 0) begin
                m_valid[i] = 1; m_mode[i] = 1;
            end else if (old_mode == 1) begin
                if (((cand - m_sync[i] + 8) % 8) == 1) begin
                    m_step[i] = 1;
                    if (cand == int'(match_val)) m_match[i] = 1;
                    if (m_sync[i] == 7) begin
                        m_wrap[i] = 1;
                        if (m_wcnt[i] < WMAX[i]) m_wcnt[i]++;
                    end
                end else begin
                    m_err[i] = 1; m_mode[i] = 2;
                end
            end
            m_sync[i] = cand;
        end
        if (clr) begin
            m_wcnt[i] = 0;
            if (old_mode == 2) begin
                m_err[i] = 0; m_valid[i] = 0; m_mode[i] = 0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_hist.delete();
            m_s1v = 0; m_s1 = 0;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0; m_sync[i] = 0; m_step[i] = 0; m_wrap[i] = 0;
                m_match[i] = 0; m_wcnt[i] = 0; m_err[i] = 0; m_mode[i] = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) model_edge(i);
            if (m_s1v) begin
                q_hist.push_back(m_s1);
                if (q_hist.size() > 20) void'(q_hist.pop_front());
            end
            m_s1 = int'(ripple_count);
            m_s1v = 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    int ca_step = 0, ca_wrap = 0, ca_match = 0, cb_step = 0, cb_wrap = 0;

    always @(negedge clk) begin
        chk("a_valid", a_valid, m_valid[0]);
        chk("a_sync",  a_sync,  m_sync[0]);
        chk("a_step",  a_step,  m_step[0]);
        chk("a_wrap",  a_wrap,  m_wrap[0]);
        chk("a_match", a_match, m_match[0]);
        chk("a_wcnt",  a_wcnt,  m_wcnt[0]);
        chk("a_err",   a_err,   m_err[0]);
        chk("b_valid", b_valid, m_valid[1]);
        chk("b_sync",  b_sync,  m_sync[1]);
        chk("b_step",  b_step,  m_step[1]);
        chk("b_wrap",  b_wrap,  m_wrap[1]);
        chk("b_match", b_match, m_match[1]);
        chk("b_wcnt",  b_wcnt,  m_wcnt[1]);
        chk("b_err",   b_err,   m_err[1]);
        if (a_step)  ca_step++;
        if (a_wrap)  ca_wrap++;
        if (a_match) ca_match++;
        if (b_step)  cb_step++;
        if (b_wrap)  cb_wrap++;
    end

    // ---------------- stimulus ----------------
    int cur = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_counts();
        ca_step = 0; ca_wrap = 0; ca_match = 0; cb_step = 0; cb_wrap = 0;
    endtask

    // +1 step with the ripple transients of a JK ripple counter, one cycle each
    task automatic inc(input int hold);
        int v = cur;
        int b = 0;
        int was1;
        while (b < 3) begin
            was1 = (v >> b) & 1;
            v = v ^ (1 << b);
            if (was1 == 1 && b < 2) begin
                ripple_count = 3'(v);
                tick(1);
                b++;
            end else begin
                b = 3;
            end
        end
        cur = (cur + 1) % 8;
        ripple_count = 3'(cur);
        tick(hold);
    endtask

    task automatic set_val(input int v, input int hold);
        cur = v;
        ripple_count = 3'(v);
        tick(hold);
    endtask

    task automatic do_reset(input int v);
        rst = 1'b1; clr = 1'b0;
        cur = v; ripple_count = 3'(v);
        tick(2);
        rst = 1'b0;
        tick(8);
    endtask

    initial begin
        #5000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        // reset release with 5 -> baseline on edge 4 (dut_a) / edge 5 (dut_b)
        rst = 1'b1; cur = 5; ripple_count = 3'd5;
        tick(2);
        rst = 1'b0;
        chk("rst_a_sync", a_sync, 0);
        chk("rst_a_valid", a_valid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("e3_a_valid", a_valid, 0);
        @(negedge clk);
        chk("e4_a_sync", a_sync, 5);
        chk("e4_a_valid", a_valid, 1);
        chk("e4_a_step", a_step, 0);
        chk("e4_b_sync", b_sync, 0);
        @(negedge clk);
        chk("e5_b_sync", b_sync, 5);
        chk("e5_b_valid", b_valid, 1);
        tick(4);

        // 3 -> 4 with transients 2, 0
        do_reset(3);
        clear_counts();
        inc(6);
        chk("glitch_a_steps", ca_step, 1);
        chk("glitch_b_steps", cb_step, 1);
        chk("glitch_a_sync", a_sync, 4);
        chk("glitch_a_err", a_err, 0);

        // full sweep 0..7..0 with match_val 6
        do_reset(0);
        match_val = 3'd6;
        clear_counts();
        repeat (8) inc(6);
        chk("sweep_a_steps", ca_step, 8);
        chk("sweep_a_wraps", ca_wrap, 1);
        chk("sweep_a_match", ca_match, 1);
        chk("sweep_a_wcnt", a_wcnt, 1);
        chk("sweep_b_wcnt", b_wcnt, 1);
        chk("sweep_a_err", a_err, 0);

        // illegal jump, error hold, clear and re-baseline
        do_reset(2);
        clear_counts();
        set_val(5, 8);
        chk("jump_a_err", a_err, 1);
        chk("jump_b_err", b_err, 1);
        inc(8);
        inc(8);
        chk("err_a_sync", a_sync, 7);
        chk("err_a_steps", ca_step, 0);
        clr = 1'b1; tick(1); clr = 1'b0;
        @(negedge clk);
        chk("clr_a_err", a_err, 0);
        chk("clr_a_valid", a_valid, 0);
        inc(8);
        chk("rebase_a_valid", a_valid, 1);
        chk("rebase_a_sync", a_sync, 0);
        chk("rebase_a_steps", ca_step, 0);
        chk("rebase_b_steps", cb_step, 0);

        // wrap saturation and clear coincident with a wrap
        do_reset(0);
        clear_counts();
        repeat (40) inc(4);
        chk("sat_a_wcnt", a_wcnt, 5);
        chk("sat_b_wcnt", b_wcnt, 3);
        repeat (7) inc(4);
        inc(0);
        tick(3);
        clr = 1'b1; tick(1); clr = 1'b0;
        @(negedge clk);
        chk("clrwrap_a_pulse", a_wrap, 1);
        chk("clrwrap_a_wcnt", a_wcnt, 0);
        tick(4);
        repeat (7) inc(5);
        inc(0);
        tick(4);
        clr = 1'b1; tick(1); clr = 1'b0;
        @(negedge clk);
        chk("clrwrap_b_pulse", b_wrap, 1);
        chk("clrwrap_b_wcnt", b_wcnt, 0);
        tick(4);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            int r = int'($urandom_range(0, 99));
            if (r < 70) begin
                inc(int'($urandom_range(1, 8)));
            end else if (r < 80) begin
                set_val(int'($urandom_range(0, 7)), int'($urandom_range(1, 8)));
            end else if (r < 89) begin
                clr = 1'b1; tick(1); clr = 1'b0;
            end else if (r < 97) begin
                match_val = 3'($urandom_range(0, 7));
                tick(1);
            end else begin
                do_reset(int'($urandom_range(0, 7)));
            end
        end
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
